serial_normalizer: RTL
======================

SERIAL_NORMALIZER -- requirements
Module: serial_normalizer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A  input  32  operand.
REQ-007 Mode  input  2  00 leading-zero (LZ), 01 leading-sign (LS), 10 trailing-zero (TZ), 11 reserved.
REQ-008 out_valid  output  1  Result/Count valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 Result  output  32  normalized operand.
REQ-011 Count  output  6  shift amount applied, 0..32.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, latch A into a work register and Mode, clear Count to 0, go to BUSY.
REQ-014 BUSY: in_ready=0, out_valid=0; each cycle, evaluate the stop condition on the work register; if true go to DONE, else shift by one bit and increment Count.
REQ-015 LZ stop: bit31==1 or Count==32; shift is logical left by 1.
REQ-016 LS stop: bit31!=bit30 or Count==31; shift is left by 1.
REQ-017 TZ stop: bit0==1 or Count==32; shift is logical right by 1.
REQ-018 Mode 11 SHALL stop immediately: Count=0, Result=A.
REQ-019 Latency: out_valid SHALL rise exactly Count+1 cycles after the acceptance edge; at most one bit is shifted per cycle.
REQ-020 DONE: out_valid=1, in_ready=0; Result and Count SHALL be held stable until out_valid&out_ready; on that edge, go to IDLE.
REQ-021 No new request SHALL be accepted in the cycle of result handshake; in_ready rises the following cycle.
REQ-022 in_valid/A/Mode changes during BUSY or DONE SHALL have no effect.
REQ-023 Boundaries: LZ or TZ with A=0 yields Count=32, Result=0; LS with A=0 yields Count=31, Result=0; LS with A=0xFFFFFFFF yields Count=31, Result=0x80000000.

Reset
REQ-024 With rst=1 at a rising edge, the FSM SHALL enter IDLE and Result=0, Count=0, out_valid=0; in_ready=1 after reset is released.
REQ-025 rst in BUSY or DONE SHALL discard the in-flight operation; no result is emitted.

Structure
REQ-026 A shared package SHALL hold DATA_WIDTH, the Mode encodings (LZ/LS/TZ/reserved), and the FSM state encodings.
REQ-027 One sub-module norm_stop_detect (combinational: work register, Mode, Count -> stop) SHALL be instantiated; the shift and count datapath stays in the top level.

Verification
REQ-028 LZ, A=0x00F00000 -> Count=8, Result=0xF0000000, out_valid 9 cycles after accept.
REQ-029 LZ, A=0x00000000 -> Count=32, Result=0x00000000, out_valid 33 cycles after accept.
REQ-030 LS, A=0xFFFF8000 -> Count=16, Result=0x80000000; LS, A=0x40000000 -> Count=0, out_valid 1 cycle after accept.
REQ-031 TZ, A=0x00000400 -> Count=10, Result=0x00000001; Mode 11, A=0x12345678 -> Count=0, Result=0x12345678.
REQ-032 Backpressure: out_ready held 0 for 5 cycles in DONE -> Result/Count stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle; back-to-back requests are both completed correctly.
REQ-033 rst pulsed 3 cycles into BUSY (LZ, A=0x00000001) -> next cycle IDLE, out_valid=0, Count=0, Result=0; no stale out_valid thereafter.

Source files
------------

// File: rtl/serial_normalizer_pkg.sv
// Shared widths, mode encodings and FSM state encodings for the serial normalizer.
package serial_normalizer_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 6;

  typedef enum logic [1:0] {
    MODE_LZ  = 2'b00,
    MODE_LS  = 2'b01,
    MODE_TZ  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_normalizer_stop_detect.sv
// Combinational stop condition for one normalization step on the work register.
module norm_stop_detect
  import serial_normalizer_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] work,
  input  mode_e                 mode,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic                  stop
);

  always_comb begin
    stop = 1'b1;
    case (mode)
      MODE_LZ: stop = work[DATA_WIDTH-1] || (count == CNT_WIDTH'(DATA_WIDTH));
      // Sign run can never exceed 31 bits: the top bit is always a sign bit.
      MODE_LS: stop = (work[DATA_WIDTH-1] != work[DATA_WIDTH-2]) ||
                      (count == CNT_WIDTH'(DATA_WIDTH - 1));
      MODE_TZ: stop = work[0] || (count == CNT_WIDTH'(DATA_WIDTH));
      default: stop = 1'b1;
    endcase
  end

endmodule

// File: rtl/serial_normalizer.sv
// Bit-serial normalizer: shifts the operand one bit per cycle until the
// leading-zero, leading-sign or trailing-zero run is consumed.
module serial_normalizer
  import serial_normalizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [1:0]            Mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [5:0]            Count
);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [5:0]            count_q, count_d;
  logic                  stop;

  norm_stop_detect u_stop (
    .work  (work_q),
    .mode  (mode_q),
    .count (count_q),
    .stop  (stop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_LZ;
      work_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      work_q  <= work_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    work_d  = work_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d  = mode_e'(Mode);
          work_d  = A;
          count_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (stop) begin
          state_d = ST_DONE;
        end else begin
          work_d  = (mode_q == MODE_TZ) ? (work_q >> 1) : (work_q << 1);
          count_d = count_q + 6'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    Result    = work_q;
    Count     = count_q;
  end

endmodule
